alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares one combinational ALU among NREQ requesters. Each requester issues an operation (A, B, op) over a valid/ready handshake. The arbiter latches the winning request, drives the ALU from registered operands, and returns the registered result on a single tagged response channel with backpressure. It sits between the instruction-issue logic of several agents and the single shared ALU instance.

## Interface
- N, 16, operand/result width
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester-ID width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ×N  operand A per requester
- req_b  in  NREQ×N  operand B per requester
- req_op  in  NREQ×3  alu_op_t per requester
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of the requester served
- rsp_result  out  N  ALU result
- rsp_carry  out  1  ALU carry/borrow/shifted-out bit
- rsp_zero  out  1  result == 0
- rsp_err  out  1  op code was illegal (3'd7)
- busy  out  1  state != IDLE
- ops_done  out  16  count of completed response handshakes, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is set, grant = first set bit searching upward from (last_grant+1) mod NREQ. Drive req_ready[grant]=1 combinationally in the same cycle. At the edge, latch a/b/op/id, update last_grant, go to EXEC. With no request, stay in IDLE and hold req_ready=0.
- EXEC: the ALU sees latched operands. At the edge, capture result/carry/zero/err into response registers, set rsp_valid, go to RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready at an edge: clear rsp_valid, increment ops_done, go to IDLE.
- req_ready is 0 in EXEC and RESP. Requesters hold valid and payload until ready; dropping valid before acceptance is allowed and simply withdraws the request.
- ALU semantics:
  - ADD: {carry,result} = A+B.
  - SUB: result = A−B, carry = (A<B) unsigned.
  - AND/OR/XOR: carry = 0.
  - SHL: carry = A[N−1], result = A<<B.
  - SHR: carry = A[0], result = A>>B.
  - Shift amount is all of B; B ≥ N yields result 0.
  - zero = (result == 0).
- Illegal op 7: result 0, carry 0, zero 1, rsp_err 1. Never leave the ALU outputs undriven.
- Reset values: state IDLE, last_grant NREQ−1 (requester 0 wins first), req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_carry 0, rsp_zero 0, rsp_err 0, busy 0, ops_done 0.
- Reset asserted mid-transaction drops the transaction. No response is produced, and the requester must reissue.
- Simultaneous requests are served strictly round-robin. No requester waits more than NREQ−1 other grants.

## Timing
- Accept at edge e: rsp_valid rises after edge e+1. Fixed latency 2 cycles from accept to response valid.
- Earliest next accept is the cycle after the response handshake. Peak throughput is 1 op per 3 cycles with rsp_ready tied high.
- req_ready is combinational from req_valid and state (no path from rsp_ready). All rsp_* outputs and busy are registered.
- ops_done wraps 16'hFFFF → 0.

## Structure
- Shared package alu_pkg:
  - alu_op_t (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHIFT_LEFT=5, SHIFT_RIGHT=6), with 7 reserved as illegal.
  - alu_arb_state_t {IDLE, EXEC, RESP}.
- One sub-module: rr_arbiter (NREQ), which takes the request vector and last_grant and outputs a one-hot grant plus an index.
- The arbiter instantiates the team's ALU with its ops from alu_pkg. Add a default branch there for op 7.

## Test plan
- Single request: req 2 issues ADD A=16'hFFFF, B=1, rsp_ready=1. Expected: ready[2] pulses once, 2 cycles later rsp_valid with id 2, result 0, carry 1, zero 1.
- All four request SUB continuously from reset. Expected: grants in order 0,1,2,3,0, each requester appears once per 4 responses, ops_done=5 after 5 handshakes.
- Backpressure: XOR A=16'h00F0, B=16'h00FF with rsp_ready=0 for 5 cycles. Expected: rsp_result=16'h000F held stable with rsp_valid=1, req_ready all 0 throughout, and exactly one handshake when rsp_ready rises.
- Shifts and illegal op:
  - SHL A=16'h8001, B=1 → result 16'h0002, carry 1.
  - SHR B=20 → result 0, zero 1.
  - op 7 → rsp_err 1, result 0.
- Reset mid-op: assert rst in EXEC. Expected: rsp_valid 0, busy 0, ops_done 0 immediately (asynchronous), and after release requester 0 wins first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and arbiter state encoding
package alu_pkg;
  typedef enum logic [2:0] {
    ADD         = 3'd0,
    SUB         = 3'd1,
    AND         = 3'd2,
    OR          = 3'd3,
    XOR         = 3'd4,
    SHIFT_LEFT  = 3'd5,
    SHIFT_RIGHT = 3'd6
  } alu_op_t;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request searching upward from last+1 mod NREQ; outputs one-hot gnt, its idx and req_any
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            req_any
);
  logic [IDW-1:0] c;
  always_comb begin
    idx = '0;
    req_any = 1'b0;
    c = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = IDW'((int'(last) + i) % NREQ);
      if (req[c]) begin
        idx = c;
        req_any = 1'b1;
      end
    end
    gnt = req_any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU among NREQ valid/ready requesters, registered tagged response with backpressure
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       ops_done
);
  alu_arb_state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_idx;
  logic [N-1:0] a_q, a_d, b_q, b_d, rsp_result_q, rsp_result_d, alu_res;
  logic [2:0] op_q, op_d;
  logic rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
  logic rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic alu_carry, alu_err, req_any;
  logic [15:0] ops_q, ops_d;
  logic [NREQ-1:0] gnt;
  logic [N:0] sum;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req(req_valid), .last(last_q), .gnt(gnt), .idx(gnt_idx), .req_any(req_any)
  );
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    alu_res = '0;
    alu_carry = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      ADD:         {alu_carry, alu_res} = sum;
      SUB:         begin alu_res = a_q - b_q; alu_carry = a_q < b_q; end
      AND:         alu_res = a_q & b_q;
      OR:          alu_res = a_q | b_q;
      XOR:         alu_res = a_q ^ b_q;
      SHIFT_LEFT:  begin alu_res = a_q << b_q; alu_carry = a_q[N-1]; end
      SHIFT_RIGHT: begin alu_res = a_q >> b_q; alu_carry = a_q[0]; end
      default:     alu_err = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d = rsp_err_q;
    ops_d = ops_q;
    case (state_q)
      IDLE: if (req_any) begin
        a_d = req_a[gnt_idx*N +: N];
        b_d = req_b[gnt_idx*N +: N];
        op_d = req_op[gnt_idx*3 +: 3];
        id_d = gnt_idx;
        last_d = gnt_idx;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d = id_q;
        rsp_result_d = alu_res;
        rsp_carry_d = alu_carry;
        rsp_zero_d = alu_res == '0;
        rsp_err_d = alu_err;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        ops_d = ops_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_result_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q <= 1'b0;
      ops_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q <= rsp_err_d;
      ops_q <= ops_d;
    end
  end
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err = rsp_err_q;
  assign busy = state_q != IDLE;
  assign ops_done = ops_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with per-requester drivers and a reference ALU model
module tb_alu_arbiter;
  localparam int N = 16;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, acc;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_op;
  logic rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err, busy;
  logic [IDW-1:0] rsp_id, last_id;
  logic [N-1:0] rsp_result, last_res;
  logic [15:0] ops_done, ops_before;
  logic last_c, last_z, last_e, prev_v;
  logic [N-1:0] ra[NREQ], rb[NREQ];
  logic [2:0] rop[NREQ];
  int rem[NREQ], pulses[NREQ];
  int grants[$];
  int cyc, n_cmp, n_bad, force_op, k;
  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0] res;
    logic c, z, e;
    int t;
  } exp_t;
  exp_t q[$];
  exp_t ex;
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = ra[i];
      req_b[i*N +: N] = rb[i];
      req_op[i*3 +: 3] = rop[i];
    end
  end
  alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [2:0] op, input int t);
    exp_t e;
    logic [N:0] s;
    e.id = IDW'(id);
    e.res = '0;
    e.c = 1'b0;
    e.e = 1'b0;
    e.t = t;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      3'd0: begin e.res = s[N-1:0]; e.c = s[N]; end
      3'd1: begin e.res = a - b; e.c = a < b; end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin e.c = a[N-1]; e.res = (b >= N) ? '0 : a << b[3:0]; end
      3'd6: begin e.c = a[0]; e.res = (b >= N) ? '0 : a >> b[3:0]; end
      default: e.e = 1'b1;
    endcase
    e.z = e.res == '0;
    return e;
  endfunction
  task automatic new_payload(input int i);
    ra[i] = N'($urandom);
    rb[i] = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 20)) : N'($urandom);
    rop[i] = (force_op >= 0) ? 3'(force_op) : 3'($urandom_range(0, 7));
  endtask
  task automatic issue(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    ra[i] = a;
    rb[i] = b;
    rop[i] = op;
    rem[i] = 0;
    req_valid[i] = 1'b1;
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("ready_legal", 32'($countones(req_ready) <= 1 && (req_ready & ~req_valid) == '0), 1);
    if (busy) chk("ready_busy", 32'(req_ready), 0);
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        q.push_back(model(i, ra[i], rb[i], rop[i], cyc));
        grants.push_back(i);
        pulses[i]++;
        acc[i] = 1'b1;
      end
    if (rsp_valid && !prev_v) begin
      if (q.size() > 0) chk("latency", 32'(cyc - q[0].t), 2);
      else chk("spurious_rsp", 1, 0);
    end
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        ex = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(ex.id));
        chk("rsp_result", 32'(rsp_result), 32'(ex.res));
        chk("rsp_carry", 32'(rsp_carry), 32'(ex.c));
        chk("rsp_zero", 32'(rsp_zero), 32'(ex.z));
        chk("rsp_err", 32'(rsp_err), 32'(ex.e));
      end
      last_id = rsp_id;
      last_res = rsp_result;
      last_c = rsp_carry;
      last_z = rsp_zero;
      last_e = rsp_err;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          new_payload(i);
        end else req_valid[i] = 1'b0;
      end
  endtask
  task automatic run_idle(input int maxc);
    int n = 0;
    while ((req_valid != '0 || q.size() != 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    chk("drained", 32'(req_valid == '0 && q.size() == 0 && !busy), 1);
  endtask
  task automatic clear_tb();
    q.delete();
    req_valid = '0;
    acc = '0;
    prev_v = 1'b0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    force_op = -1;
    rsp_ready = 1'b1;
    clear_tb();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      rop[i] = '0;
      pulses[i] = 0;
    end
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_carry", 32'(rsp_carry), 0);
    chk("rst_rsp_zero", 32'(rsp_zero), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(2, 16'hFFFF, 16'h0001, 3'd0);
    run_idle(20);
    chk("single_pulses", 32'(pulses[2]), 1);
    chk("single_id", 32'(last_id), 2);
    chk("single_res", 32'(last_res), 0);
    chk("single_carry", 32'(last_c), 1);
    chk("single_zero", 32'(last_z), 1);
    do_reset();
    force_op = 1;
    grants.delete();
    for (int i = 0; i < NREQ; i++) begin
      new_payload(i);
      rem[i] = (i == 0) ? 1 : 0;
    end
    req_valid = '1;
    run_idle(100);
    force_op = -1;
    chk("rr_count", 32'(grants.size()), 5);
    for (int j = 0; j < 5; j++) chk("rr_order", 32'((grants.size() > j) ? grants[j] : -1), 32'(j % NREQ));
    chk("rr_ops_done", 32'(ops_done), 5);
    rsp_ready = 1'b0;
    issue(1, 16'h00F0, 16'h00FF, 3'd4);
    issue(3, 16'h1234, 16'h0001, 3'd0);
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    chk("bp_valid_seen", 32'(rsp_valid), 1);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_valid_held", 32'(rsp_valid), 1);
      chk("bp_result_held", 32'(rsp_result), 'h000F);
      chk("bp_id_held", 32'(rsp_id), 1);
      chk("bp_ready_low", 32'(req_ready), 0);
    end
    ops_before = ops_done;
    rsp_ready = 1'b1;
    tick();
    chk("bp_one_handshake", 32'(ops_done), 32'(ops_before + 16'd1));
    chk("bp_res", 32'(last_res), 'h000F);
    run_idle(30);
    chk("bp_total", 32'(ops_done), 32'(ops_before + 16'd2));
    issue(0, 16'h8001, 16'h0001, 3'd5);
    run_idle(20);
    chk("shl_res", 32'(last_res), 'h0002);
    chk("shl_carry", 32'(last_c), 1);
    issue(0, 16'hBEEF, 16'd20, 3'd6);
    run_idle(20);
    chk("shr_res", 32'(last_res), 0);
    chk("shr_zero", 32'(last_z), 1);
    issue(0, 16'h1234, 16'h0005, 3'd7);
    run_idle(20);
    chk("ill_err", 32'(last_e), 1);
    chk("ill_res", 32'(last_res), 0);
    chk("ill_zero", 32'(last_z), 1);
    for (int j = 0; j < 300; j++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          new_payload(i);
          rem[i] = 0;
          req_valid[i] = 1'b1;
        end
      tick();
    end
    rsp_ready = 1'b1;
    run_idle(200);
    issue(2, 16'h0001, 16'h0002, 3'd0);
    k = 0;
    while (!busy && k < 10) begin
      tick();
      k++;
    end
    chk("mid_in_exec", 32'(busy && !rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_ops_done", 32'(ops_done), 0);
    clear_tb();
    @(posedge clk);
    #1 rst = 1'b0;
    grants.delete();
    for (int i = 0; i < NREQ; i++) new_payload(i);
    req_valid = '1;
    run_idle(60);
    chk("post_rst_first", 32'((grants.size() > 0) ? grants[0] : -1), 0);
    chk("post_rst_ops", 32'(ops_done), 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
